// File: rtl/key_pkg.sv
// Shared types and constants for the PS/2-style key frame receiver.
package key_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Odd parity holds when data plus parity carries an odd number of ones.
  function automatic logic odd_par_ok(input logic [DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/key_code_fifo.sv
// Show-ahead FIFO for received key codes; push is dropped when full unless a pop frees a slot.
module key_code_fifo
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [CW-1:0]     wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_pop, do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + CW'(1);
      if (do_pop)  rd_q <= rd_q + CW'(1);
    end
  end

  // Storage; cleared on reset so the head reads 0x00 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/key_frame_rx.sv
// Keyboard serial frame receiver: synchronizes kb_clk/kb_data, decodes 11-bit
// odd-parity frames, aborts stalled frames, and queues good codes in a FIFO.
module key_frame_rx
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500,
  localparam int CW  = $clog2(FIFO_DEPTH) + 1,
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1),
  localparam int BCW = $clog2(FRAME_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kb_clk,
  input  logic              kb_data,
  output logic [DATA_W-1:0] code_data,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [CW-1:0]     fifo_count
);

  logic [1:0]        kclk_q, kdat_q;
  logic              kclk_prev_q;
  logic              sample, sbit;

  rx_state_e         state_q, state_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              err_q, err_d;
  logic              ovf_q;

  logic              fifo_full, fifo_empty, pop;

  // Two-flop synchronizers plus a delayed copy of kb_clk for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_q      <= '1;
      kdat_q      <= '1;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_q      <= {kclk_q[0], kb_clk};
      kdat_q      <= {kdat_q[0], kb_data};
      kclk_prev_q <= kclk_q[1];
    end
  end

  assign sample = kclk_prev_q & ~kclk_q[1];
  assign sbit   = kdat_q[1];

  // Frame decode, timeout and push/error generation.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    push_d   = 1'b0;
    code_d   = code_q;
    err_d    = 1'b0;
    tmo_d    = (state_q == ST_IDLE || sample) ? '0 : tmo_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (sample && !sbit) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d  = {sbit, shift_q[DATA_W-1:1]};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == BCW'(DATA_W - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_d   = sbit;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d = ST_IDLE;
          if (sbit && odd_par_ok(shift_q, par_q)) begin
            push_d = 1'b1;
            code_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled partial frame is abandoned after TIMEOUT_CYCLES without an edge.
    if (state_q != ST_IDLE && !sample && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      push_q   <= 1'b0;
      code_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      push_q   <= push_d;
      code_q   <= code_d;
      err_q    <= err_d;
    end
  end

  assign pop = code_ready & ~fifo_empty;

  // Overflow pulse: a good code arrived with no room and no pop freeing a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= push_q & fifo_full & ~pop;
  end

  key_code_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .wdata (code_q),
    .pop   (pop),
    .rdata (code_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign code_valid = ~fifo_empty;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/key_frame_rx.md
KEY_FRAME_RX -- requirements
Module: key_frame_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered key codes (power of two, >= 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2500, clk cycles without a kb_clk falling edge before a partial frame aborts.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port kb_clk  input  1  keyboard-driven serial clock, asynchronous to clk, idle high.
REQ-006 SHALL have port kb_data  input  1  keyboard-driven serial data, asynchronous to clk, idle high.
REQ-007 SHALL have port code_data  output  8  key code at FIFO head.
REQ-008 SHALL have port code_valid  output  1  FIFO non-empty; code_data valid.
REQ-009 SHALL have port code_ready  input  1  consumer accepts code_data when high together with code_valid.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame discarded (parity, stop or timeout).
REQ-011 SHALL have port overflow  output  1  one-cycle pulse: good frame dropped, FIFO full.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored codes.

Function
REQ-013 kb_clk and kb_data SHALL each pass a 2-flop synchronizer; a sample event is a synchronized kb_clk 1->0 transition, with kb_data taken from the same synchronized stage.
REQ-014 Frame format SHALL be 11 bits: start 0, 8 data LSB first, odd parity (data+parity ones count odd), stop 1.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: sample with data 0 -> DATA, bit counter 0; sample with data 1 -> stay IDLE, no error.
REQ-017 DATA: each sample shifts data into bit 7 of shift register (right shift); after the 8th -> PARITY.
REQ-018 PARITY: sample captures parity bit -> STOP.
REQ-019 STOP: sample; stop 1 and parity good -> push code, else frame_err pulse; always -> IDLE.
REQ-020 Push SHALL occur on the clk after the stop sample; code_valid SHALL rise on the following clk edge if FIFO was empty.
REQ-021 Timeout counter SHALL reset on every sample and when in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> frame_err pulse, partial frame discarded, IDLE.
REQ-022 FIFO SHALL be show-ahead: code_data equals oldest entry whenever code_valid; pop when code_valid and code_ready.
REQ-023 Push while full with no pop SHALL drop the new code, assert overflow one cycle, leave FIFO unchanged.
REQ-024 Push while full with simultaneous pop SHALL accept the new code; no overflow; count unchanged.
REQ-025 Push and pop on non-full non-empty FIFO SHALL leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-026 code_ready while code_valid low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, bit counter 0, shift register 0x00, timeout counter 0, FIFO empty, code_valid 0, code_data 0x00, frame_err 0, overflow 0, fifo_count 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial frame without frame_err; reception restarts at the next start bit after release.

Structure
REQ-029 Shared package key_pkg SHALL hold the FSM state enum, frame bit count constant (11) and data width (8).
REQ-030 FIFO SHALL be a separate sub-module key_code_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/full/empty/count); rest stays in key_frame_rx.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, code_ready 1 -> code_data 0x1C, code_valid one cycle, frame_err 0.
REQ-032 Frame 0x1C with parity 1 -> frame_err one pulse, code_valid stays 0, fifo_count 0.
REQ-033 Five good frames 0x01..0x05, code_ready 0 -> fifo_count 4, overflow pulse on 5th; then drain reads 0x01,0x02,0x03,0x04.
REQ-034 Start + 4 data bits then kb_clk idle -> frame_err exactly TIMEOUT_CYCLES after last edge; next frame 0xF0 parity 1 -> received 0xF0.
REQ-035 rst_n low after 6 bits of a frame -> all outputs at reset values, no frame_err; following frame 0x00 parity 1 -> received 0x00.
REQ-036 FIFO full, code_ready 1 in the push cycle of 0xAA -> no overflow, fifo_count stays 4, 0xAA read last.
